// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the sliding-window generator.
package conv_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} conv_win_state_t;
   function automatic int win_per_frame(int img_w, int img_h, int k, int stride);
      return ((img_w - k) / stride + 1) * ((img_h - k) / stride + 1);
   endfunction
   // element (0,0) lands in the most significant slot, row-major toward the LSBs
   function automatic int win_idx(int k, int r, int c);
      return k * k - 1 - (r * k + c);
   endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: K-1 line FIFOs feeding a KxK shift-register window.
// o_window is the window as it will stand after the current shift.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 8,
   parameter int K      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_shift,
   input  logic [DATA_W-1:0]     i_pixel,
   output logic [K*K*DATA_W-1:0] o_window
);
   logic [DATA_W-1:0] r_line [K-1][IMG_W];
   logic [DATA_W-1:0] r_win  [K][K];
   logic [DATA_W-1:0] w_tap  [K];
   // w_tap[K-1] is the new pixel, lower indices are the pixels one line further up
   always_comb begin
      w_tap = '{default: '0};
      w_tap[K-1] = i_pixel;
      for (int i = 0; i < K - 1; i++) w_tap[K-2-i] = r_line[i][IMG_W-1];
   end
   always_comb begin
      o_window = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) o_window[win_idx(K, r, c)*DATA_W +: DATA_W] = r_win[r][c+1];
         o_window[win_idx(K, r, K - 1)*DATA_W +: DATA_W] = w_tap[r];
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_line <= '{default: '0};
         r_win  <= '{default: '0};
      end else if (i_shift) begin
         for (int i = 0; i < K - 1; i++) begin
            r_line[i][0] <= w_tap[K-1-i];
            for (int j = 1; j < IMG_W; j++) r_line[i][j] <= r_line[i][j-1];
         end
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) r_win[r][c] <= r_win[r][c+1];
            r_win[r][K-1] <= w_tap[r];
         end
      end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: fetches a raster image from a pixel ROM and streams KxK windows at STRIDE.
// Define CONV_WIN_COORD_EN to add o_row/o_col output-map coordinates.
module conv_window_gen
   import conv_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int IMG_W  = 8,
   parameter  int IMG_H  = 8,
   parameter  int K      = 3,
   parameter  int STRIDE = 1,
   parameter  int ADDR_W = $clog2(IMG_W * IMG_H),
   localparam int CW     = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [DATA_W-1:0]     pixel_in,
   output logic [ADDR_W-1:0]     rom_addr,
   output logic [K*K*DATA_W-1:0] o_window,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic                  o_frame_done
`ifdef CONV_WIN_COORD_EN
   ,
   output logic [CW-1:0]         o_row,
   output logic [CW-1:0]         o_col
`endif
);
   // bottom-right pixel of the final window; trailing pixels beyond it are discarded
   localparam int LR = K - 1 + ((IMG_H - K) / STRIDE) * STRIDE;
   localparam int LC = K - 1 + ((IMG_W - K) / STRIDE) * STRIDE;
   localparam int SW = STRIDE > 1 ? $clog2(STRIDE) : 1;
   conv_win_state_t       r_state;
   logic [CW-1:0]         r_row, r_col;
   logic [SW-1:0]         r_rph, r_cph;
   logic                  r_is_last, r_last_acc;
   logic [K*K*DATA_W-1:0] w_win;
   logic w_stall, w_acc, w_step, w_col_end, w_row_end, w_frame_end;
   logic w_row_ok, w_col_ok, w_load, w_last, w_done;
   logic [SW-1:0] w_rph_nxt, w_cph_nxt;
   assign w_stall     = o_valid && !o_ready;
   assign w_acc       = o_valid && o_ready;
   assign w_step      = r_state == FETCH && enable && !w_stall;
   assign w_col_end   = r_col == CW'(IMG_W - 1);
   assign w_row_end   = r_row == CW'(IMG_H - 1);
   assign w_frame_end = w_col_end && w_row_end;
   assign w_row_ok    = r_row >= CW'(K - 1) && r_rph == '0;
   assign w_col_ok    = r_col >= CW'(K - 1) && r_cph == '0;
   assign w_load      = w_step && w_row_ok && w_col_ok;
   assign w_last      = r_row == CW'(LR) && r_col == CW'(LC);
   assign w_done      = w_acc && r_is_last;
   assign w_rph_nxt   = r_rph == SW'(STRIDE - 1) ? '0 : r_rph + SW'(1);
   assign w_cph_nxt   = r_cph == SW'(STRIDE - 1) ? '0 : r_cph + SW'(1);
   conv_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .K(K)) u_lb (
      .clk(clk),
      .rst(rst),
      .i_shift(w_step),
      .i_pixel(pixel_in),
      .o_window(w_win)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state      <= IDLE;
         rom_addr     <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_rph        <= '0;
         r_cph        <= '0;
         o_window     <= '0;
         o_valid      <= 1'b0;
         o_frame_done <= 1'b0;
         r_is_last    <= 1'b0;
         r_last_acc   <= 1'b0;
      end else begin
         o_frame_done <= w_done;
         if (w_load) begin
            o_window  <= w_win;
            o_valid   <= 1'b1;
            r_is_last <= w_last;
         end else if (w_acc) begin
            o_valid   <= 1'b0;
            r_is_last <= 1'b0;
         end
         if (w_done) r_last_acc <= 1'b1;
         if (r_state == IDLE) begin
            rom_addr   <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_rph      <= '0;
            r_cph      <= '0;
            r_last_acc <= 1'b0;
            if (enable) r_state <= FETCH;
         end else if (r_state == FETCH) begin
            if (w_step) begin
               rom_addr <= w_frame_end ? '0 : rom_addr + ADDR_W'(1);
               r_col    <= w_col_end ? '0 : r_col + CW'(1);
               r_cph    <= w_col_end ? '0 : r_col >= CW'(K - 1) ? w_cph_nxt : r_cph;
               if (w_col_end) begin
                  r_row <= w_row_end ? '0 : r_row + CW'(1);
                  r_rph <= w_row_end ? '0 : r_row >= CW'(K - 1) ? w_rph_nxt : r_rph;
               end
               if (w_frame_end) r_state <= DRAIN;
            end
         end else if (r_last_acc || w_done) r_state <= IDLE;
      end
`ifdef CONV_WIN_COORD_EN
   logic [CW-1:0] r_wrow, r_wcol;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wrow <= '0;
         r_wcol <= '0;
         o_row  <= '0;
         o_col  <= '0;
      end else if (r_state == IDLE) begin
         r_wrow <= '0;
         r_wcol <= '0;
      end else if (w_step) begin
         if (w_load) begin
            o_row <= r_wrow;
            o_col <= r_wcol;
         end
         r_wcol <= w_col_end ? '0 : r_wcol + CW'(w_load);
         if (w_col_end && w_row_ok) r_wrow <= r_wrow + CW'(1);
      end
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed bench for conv_window_gen (default, STRIDE=2 and 6x6 instances).
module tb_conv_window_gen;
   localparam int DW = 32;
   localparam int WW = 9 * DW;
   localparam logic [WW-1:0] W_FIRST = {32'd0, 32'd1, 32'd2, 32'd8, 32'd9, 32'd10, 32'd16, 32'd17, 32'd18};
   localparam logic [WW-1:0] W_LAST  = {32'd45, 32'd46, 32'd47, 32'd53, 32'd54, 32'd55, 32'd61, 32'd62, 32'd63};
   localparam logic [WW-1:0] W_S2_1  = {32'd2, 32'd3, 32'd4, 32'd10, 32'd11, 32'd12, 32'd18, 32'd19, 32'd20};
   logic clk = 1'b0, rst = 1'b0;
   logic en_a = 1'b0, rdy_a = 1'b1, val_a, fd_a;
   logic en_b = 1'b0, rdy_b = 1'b1, val_b, fd_b;
   logic en_c = 1'b0, rdy_c = 1'b1, val_c, fd_c;
   logic [5:0] addr_a, addr_b, addr_c;
   logic [WW-1:0] win_a, win_b, win_c;
   logic [DW-1:0] pix_a, pix_b, pix_c;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   assign pix_a = DW'(addr_a);
   assign pix_b = DW'(addr_b);
   assign pix_c = DW'(addr_c);
`ifdef CONV_WIN_COORD_EN
   logic [2:0] row_a, col_a, row_b, col_b, row_c, col_c;
`endif
   conv_window_gen u_a (
      .clk(clk), .rst(rst), .enable(en_a), .pixel_in(pix_a), .rom_addr(addr_a),
      .o_window(win_a), .o_valid(val_a), .o_ready(rdy_a), .o_frame_done(fd_a)
`ifdef CONV_WIN_COORD_EN
      , .o_row(row_a), .o_col(col_a)
`endif
   );
   conv_window_gen #(.STRIDE(2)) u_b (
      .clk(clk), .rst(rst), .enable(en_b), .pixel_in(pix_b), .rom_addr(addr_b),
      .o_window(win_b), .o_valid(val_b), .o_ready(rdy_b), .o_frame_done(fd_b)
`ifdef CONV_WIN_COORD_EN
      , .o_row(row_b), .o_col(col_b)
`endif
   );
   conv_window_gen #(.IMG_W(6), .IMG_H(6)) u_c (
      .clk(clk), .rst(rst), .enable(en_c), .pixel_in(pix_c), .rom_addr(addr_c),
      .o_window(win_c), .o_valid(val_c), .o_ready(rdy_c), .o_frame_done(fd_c)
`ifdef CONV_WIN_COORD_EN
      , .o_row(row_c), .o_col(col_c)
`endif
   );
   // reference window of a raster ROM whose word equals its address
   function automatic logic [WW-1:0] exp_win(int w, int r0, int c0);
      logic [WW-1:0] e;
      e = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) e[(8 - (i * 3 + j)) * DW +: DW] = DW'((r0 + i) * w + c0 + j);
      return e;
   endfunction
   task automatic restart;
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
      rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask
   task automatic test_reset;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_cmp++; if (addr_a !== 6'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", addr_a); end
      n_cmp++; if (val_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", val_a); end
      n_cmp++; if (win_a !== '0) begin n_bad++; $display("FAIL reset_window: got %h want 0", win_a); end
      n_cmp++; if (fd_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", fd_a); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask
   task automatic test_frame;
      int t, n;
      restart(); en_a = 1'b1;
      t = 0;
      while (!val_a && t < 100) begin @(posedge clk); #1; t++; end
      n_cmp++; if (addr_a !== 6'd19) begin n_bad++; $display("FAIL frame_first_addr: got %0d want 19", addr_a); end
      n_cmp++; if (win_a !== W_FIRST) begin n_bad++; $display("FAIL frame_first_win: got %h want %h", win_a, W_FIRST); end
      n = 0; t = 0;
      while (!fd_a && t < 400) begin
         if (val_a) begin
            n_cmp++; if (win_a !== exp_win(8, n / 6, n % 6)) begin n_bad++; $display("FAIL frame_win%0d: got %h want %h", n, win_a, exp_win(8, n / 6, n % 6)); end
            if (n == 35) begin
               n_cmp++; if (win_a !== W_LAST) begin n_bad++; $display("FAIL frame_last_win: got %h want %h", win_a, W_LAST); end
            end
            n++;
         end
         @(posedge clk); #1; t++;
      end
      n_cmp++; if (fd_a !== 1'b1 || n != 36) begin n_bad++; $display("FAIL frame_count: got %0d done=%b want 36 done=1", n, fd_a); end
      n_cmp++; if (addr_a !== 6'd0) begin n_bad++; $display("FAIL frame_done_addr: got %0d want 0", addr_a); end
      @(posedge clk); #1;
      n_cmp++; if (fd_a !== 1'b0) begin n_bad++; $display("FAIL frame_done_pulse: got %b want 0", fd_a); end
      n_cmp++; if (addr_a !== 6'd0) begin n_bad++; $display("FAIL frame_idle_addr: got %0d want 0", addr_a); end
      @(posedge clk); #1;
      n_cmp++; if (addr_a !== 6'd1) begin n_bad++; $display("FAIL frame_restart_addr: got %0d want 1", addr_a); end
      en_a = 1'b0;
   endtask
   task automatic test_stall;
      int t, n;
      restart(); en_a = 1'b1;
      t = 0;
      while (!val_a && t < 100) begin @(posedge clk); #1; t++; end
      rdy_a = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         n_cmp++; if (addr_a !== 6'd19) begin n_bad++; $display("FAIL stall_addr: got %0d want 19", addr_a); end
         n_cmp++; if (val_a !== 1'b1 || win_a !== W_FIRST) begin n_bad++; $display("FAIL stall_win: got %h v=%b want %h v=1", win_a, val_a, W_FIRST); end
      end
      rdy_a = 1'b1;
      n = 0; t = 0;
      while (!fd_a && t < 400) begin
         if (val_a) begin
            n_cmp++; if (win_a !== exp_win(8, n / 6, n % 6)) begin n_bad++; $display("FAIL stall_win%0d: got %h want %h", n, win_a, exp_win(8, n / 6, n % 6)); end
            n++;
         end
         @(posedge clk); #1; t++;
      end
      n_cmp++; if (fd_a !== 1'b1 || n != 36) begin n_bad++; $display("FAIL stall_count: got %0d done=%b want 36 done=1", n, fd_a); end
      en_a = 1'b0;
   endtask
   task automatic test_pause;
      int t, n;
      logic paused;
      restart(); en_a = 1'b1;
      n = 0; t = 0; paused = 1'b0;
      while (!fd_a && t < 400) begin
         if (addr_a == 6'd42 && !paused) begin
            paused = 1'b1; en_a = 1'b0;
            repeat (10) begin
               @(posedge clk); #1;
               n_cmp++; if (addr_a !== 6'd42) begin n_bad++; $display("FAIL pause_addr: got %0d want 42", addr_a); end
               n_cmp++; if (val_a !== 1'b0) begin n_bad++; $display("FAIL pause_valid: got %b want 0", val_a); end
            end
            en_a = 1'b1;
         end
         if (val_a) begin
            n_cmp++; if (win_a !== exp_win(8, n / 6, n % 6)) begin n_bad++; $display("FAIL pause_win%0d: got %h want %h", n, win_a, exp_win(8, n / 6, n % 6)); end
            n++;
         end
         @(posedge clk); #1; t++;
      end
      n_cmp++; if (fd_a !== 1'b1 || n != 36 || !paused) begin n_bad++; $display("FAIL pause_count: got %0d done=%b paused=%b want 36 done=1 paused=1", n, fd_a, paused); end
      en_a = 1'b0;
   endtask
   task automatic test_reset_mid;
      int t;
      restart(); en_a = 1'b1;
      t = 0;
      while (addr_a != 6'd30 && t < 100) begin @(posedge clk); #1; t++; end
      n_cmp++; if (val_a !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid: got %b want 1", val_a); end
      rst = 1'b1;
      #1;
      n_cmp++; if (val_a !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", val_a); end
      n_cmp++; if (addr_a !== 6'd0) begin n_bad++; $display("FAIL rstmid_addr: got %0d want 0", addr_a); end
      en_a = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; en_a = 1'b1;
      t = 0;
      while (!val_a && t < 100) begin @(posedge clk); #1; t++; end
      n_cmp++; if (win_a !== W_FIRST || addr_a !== 6'd19) begin n_bad++; $display("FAIL rstmid_first: got %h @%0d want %h @19", win_a, addr_a, W_FIRST); end
      en_a = 1'b0;
   endtask
   task automatic test_stride2;
      int t, n;
      restart(); en_b = 1'b1;
      n = 0; t = 0;
      while (!fd_b && t < 400) begin
         if (val_b) begin
            n_cmp++; if (win_b !== exp_win(8, (n / 3) * 2, (n % 3) * 2)) begin n_bad++; $display("FAIL s2_win%0d: got %h want %h", n, win_b, exp_win(8, (n / 3) * 2, (n % 3) * 2)); end
            if (n == 1) begin
               n_cmp++; if (win_b !== W_S2_1) begin n_bad++; $display("FAIL s2_second: got %h want %h", win_b, W_S2_1); end
            end
            if (n == 3) begin
               n_cmp++; if (win_b[8*DW +: DW] !== 32'd16) begin n_bad++; $display("FAIL s2_fourth_tl: got %0d want 16", win_b[8*DW +: DW]); end
            end
            n++;
         end
         @(posedge clk); #1; t++;
      end
      n_cmp++; if (fd_b !== 1'b1 || n != 9) begin n_bad++; $display("FAIL s2_count: got %0d done=%b want 9 done=1", n, fd_b); end
      en_b = 1'b0;
   endtask
   task automatic test_coord;
      int t, n;
      restart(); en_c = 1'b1;
      n = 0; t = 0;
      while (!fd_c && t < 300) begin
         if (val_c) begin
            n_cmp++; if (win_c !== exp_win(6, n / 4, n % 4)) begin n_bad++; $display("FAIL c6_win%0d: got %h want %h", n, win_c, exp_win(6, n / 4, n % 4)); end
`ifdef CONV_WIN_COORD_EN
            n_cmp++; if (row_c !== 3'(n / 4) || col_c !== 3'(n % 4)) begin n_bad++; $display("FAIL c6_coord%0d: got (%0d,%0d) want (%0d,%0d)", n, row_c, col_c, n / 4, n % 4); end
`endif
            n++;
         end
         @(posedge clk); #1; t++;
      end
      n_cmp++; if (fd_c !== 1'b1 || n != 16) begin n_bad++; $display("FAIL c6_count: got %0d done=%b want 16 done=1", n, fd_c); end
      en_c = 1'b0;
   endtask
   initial begin
      test_reset();
      test_frame();
      test_stall();
      test_pause();
      test_reset_mid();
      test_stride2();
      test_coord();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
